// File: rtl/back_leakyrelu_derivative_pkg.sv
// Constants shared by the feed/back leaky-ReLU activation blocks.
package back_leakyrelu_derivative_pkg;

  localparam logic [31:0] FP_QUARTER  = 32'h3E80_0000;
  localparam logic [31:0] FP_HALF     = 32'h3F00_0000;
  localparam int unsigned MUL_LATENCY = 7;

  // Derivative factor chosen by the forward pre-activation sign (-0.0 is negative).
  function automatic logic [31:0] leaky_factor(input logic sign);
    return sign ? FP_QUARTER : FP_HALF;
  endfunction

endpackage

// File: rtl/back_leakyrelu_derivative_mul.sv
// FP32 multiplier, round-to-nearest-even, subnormals flushed to zero,
// fixed MUL_LATENCY-cycle pipeline with synchronous active-low reset.
module multiplier_floating_point32
  import back_leakyrelu_derivative_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  output logic        valid_out,
  output logic [31:0] out_data
);

  localparam int unsigned LAT = MUL_LATENCY;

  logic        sign_c, norm_c, guard_c, sticky_c, rnd_c, carry_c;
  logic        a_zero_c, b_zero_c, a_inf_c, b_inf_c, a_nan_c, b_nan_c;
  logic [47:0] prod_c;
  logic [22:0] mant_c;
  logic [23:0] mant_r_c;
  logic [9:0]  exp_c;
  logic [31:0] result_c;

  logic [31:0]    data_q [LAT];
  logic [LAT-1:0] valid_q;

  // Combinational product of the two operands.
  always_comb begin
    sign_c   = inA[31] ^ inB[31];
    a_zero_c = (inA[30:23] == 8'h00);
    b_zero_c = (inB[30:23] == 8'h00);
    a_inf_c  = (inA[30:23] == 8'hFF) && (inA[22:0] == 23'h0);
    b_inf_c  = (inB[30:23] == 8'hFF) && (inB[22:0] == 23'h0);
    a_nan_c  = (inA[30:23] == 8'hFF) && (inA[22:0] != 23'h0);
    b_nan_c  = (inB[30:23] == 8'hFF) && (inB[22:0] != 23'h0);
    prod_c   = 48'({1'b1, inA[22:0]}) * 48'({1'b1, inB[22:0]});
    norm_c   = prod_c[47];
    mant_c   = norm_c ? prod_c[46:24] : prod_c[45:23];
    guard_c  = norm_c ? prod_c[23] : prod_c[22];
    sticky_c = norm_c ? (|prod_c[22:0]) : (|prod_c[21:0]);
    rnd_c    = guard_c && (sticky_c || mant_c[0]);
    mant_r_c = {1'b0, mant_c} + 24'(rnd_c);
    carry_c  = mant_r_c[23];
    exp_c    = 10'(inA[30:23]) + 10'(inB[30:23]) + 10'(norm_c) + 10'(carry_c);
    result_c = {sign_c, 8'(exp_c - 10'd127), mant_r_c[22:0]};
    if (a_nan_c || b_nan_c || (a_inf_c && b_zero_c) || (b_inf_c && a_zero_c)) begin
      result_c = 32'h7FC0_0000;
    end else if (a_inf_c || b_inf_c) begin
      result_c = {sign_c, 8'hFF, 23'h0};
    end else if (a_zero_c || b_zero_c || (exp_c <= 10'd127)) begin
      result_c = {sign_c, 31'h0};
    end else if (exp_c >= 10'd382) begin
      result_c = {sign_c, 8'hFF, 23'h0};
    end
  end

  // Delay line carrying result and valid to the fixed latency.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < int'(LAT); i++) data_q[i] <= '0;
    end else begin
      valid_q   <= {valid_q[LAT-2:0], valid_in};
      data_q[0] <= result_c;
      for (int i = 1; i < int'(LAT); i++) data_q[i] <= data_q[i-1];
    end
  end

  assign valid_out = valid_q[LAT-1];
  assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/back_leakyrelu_derivative.sv
// Leaky-ReLU backward pass: buffers forward signs, scales each backward error
// by 0.25 (negative pre-activation) or 0.5 (non-negative).
module back_leakyrelu_derivative
  import back_leakyrelu_derivative_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_fwd_valid,
  input  logic [DATA_WIDTH-1:0] i_fwd_data,
  input  logic                  i_flush,
  input  logic                  i_err_valid,
  input  logic [DATA_WIDTH-1:0] i_err_data,
  output logic [DATA_WIDTH-1:0] o_err_data,
  output logic                  o_err_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DEPTH-1:0]      sign_mem;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [ADDR_WIDTH:0]   count, count_next;
  logic                  overflow_next, underflow_next;
  logic                  is_full_c, is_empty_c, push_c, pop_c, head_sign_c;
  logic [31:0]           factor_c, mul_out;
  logic                  unused_fwd_bits;

  assign unused_fwd_bits = ^i_fwd_data[DATA_WIDTH-2:0];

  // Sign FIFO next-state; flush overrides any same-cycle push or pop.
  always_comb begin
    is_full_c      = (count == DEPTH_CNT);
    is_empty_c     = (count == '0);
    push_c         = i_fwd_valid && !is_full_c && !i_flush;
    pop_c          = i_err_valid && !is_empty_c && !i_flush;
    head_sign_c    = !is_empty_c && sign_mem[rd_ptr];
    factor_c       = leaky_factor(head_sign_c);
    wr_ptr_next    = wr_ptr;
    rd_ptr_next    = rd_ptr;
    count_next     = count;
    overflow_next  = o_overflow;
    underflow_next = o_underflow;
    if (i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_c) wr_ptr_next = wr_ptr + ADDR_WIDTH'(1);
      if (pop_c)  rd_ptr_next = rd_ptr + ADDR_WIDTH'(1);
      count_next     = count + (ADDR_WIDTH+1)'(push_c) - (ADDR_WIDTH+1)'(pop_c);
      overflow_next  = o_overflow  || (i_fwd_valid && is_full_c);
      underflow_next = o_underflow || (i_err_valid && is_empty_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      count       <= count_next;
      o_full      <= (count_next == DEPTH_CNT);
      o_empty     <= (count_next == '0);
      o_overflow  <= overflow_next;
      o_underflow <= underflow_next;
    end
  end

  // Sign storage needs no reset: only entries behind the write pointer are read.
  always_ff @(posedge clk) begin
    if (push_c) sign_mem[wr_ptr] <= i_fwd_data[DATA_WIDTH-1];
  end

  multiplier_floating_point32 u_mul (
    .clk       (clk),
    .rstn      (~rst_n),
    .valid_in  (i_err_valid),
    .inA       (32'(i_err_data)),
    .inB       (factor_c),
    .valid_out (o_err_valid),
    .out_data  (mul_out)
  );

  assign o_err_data = DATA_WIDTH'(mul_out);

endmodule

// File: tb/tb_back_leakyrelu_derivative.sv
// Directed bench for back_leakyrelu_derivative with an output monitor and
// an expected-output queue of (cycle, data) pairs.
module tb_back_leakyrelu_derivative;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_fwd_valid, i_flush, i_err_valid;
  logic [31:0] i_fwd_data, i_err_data;
  logic [31:0] o_err_data;
  logic        o_err_valid, o_full, o_empty, o_overflow, o_underflow;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [63:0] mon_q[$];
  logic [63:0] exp_q[$];

  back_leakyrelu_derivative dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_fwd_valid (i_fwd_valid),
    .i_fwd_data  (i_fwd_data),
    .i_flush     (i_flush),
    .i_err_valid (i_err_valid),
    .i_err_data  (i_err_data),
    .o_err_data  (o_err_data),
    .o_err_valid (o_err_valid),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (o_err_valid === 1'b1) mon_q.push_back({32'(cyc), o_err_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One input cycle; a tracked err expects its product 7 cycles later.
  task automatic drive(input logic fv, input logic [31:0] fd, input logic ev,
                       input logic [31:0] ed, input logic fl, input logic track,
                       input logic [31:0] exp_out);
    @(negedge clk);
    i_fwd_valid = fv;
    i_fwd_data  = fd;
    i_err_valid = ev;
    i_err_data  = ed;
    i_flush     = fl;
    if (ev && track) exp_q.push_back({32'(cyc + 7), exp_out});
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic push(input logic [31:0] d);
    drive(1'b1, d, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic pop(input logic [31:0] e, input logic [31:0] exp_out);
    drive(1'b0, 32'h0, 1'b1, e, 1'b0, 1'b1, exp_out);
  endtask

  task automatic drain(input string tag);
    int n;
    repeat (10) idle();
    chk({tag, "_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cycle"}, mon_q[i][63:32], exp_q[i][63:32]);
      chk({tag, "_data"},  mon_q[i][31:0],  exp_q[i][31:0]);
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic s;
    rst_n = 1'b1;
    i_fwd_valid = 1'b0; i_fwd_data = '0; i_flush = 1'b0;
    i_err_valid = 1'b0; i_err_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    chk("rst_empty",     32'(o_empty),     32'd1);
    chk("rst_full",      32'(o_full),      32'd0);
    chk("rst_overflow",  32'(o_overflow),  32'd0);
    chk("rst_underflow", 32'(o_underflow), 32'd0);
    chk("rst_valid",     32'(o_err_valid), 32'd0);
    chk("rst_data",      o_err_data,       32'h0);

    // Ordering: negative then positive pre-activation.
    push(32'hC000_0000);
    push(32'h4040_0000);
    pop(32'h3F80_0000, 32'h3E80_0000);
    pop(32'h3F80_0000, 32'h3F00_0000);
    idle();
    chk("order_empty", 32'(o_empty), 32'd1);
    chk("order_uflow", 32'(o_underflow), 32'd0);
    drain("order");

    // Underflow: empty buffer uses 0.5.
    pop(32'h4000_0000, 32'h3F80_0000);
    idle();
    chk("uflow_flag", 32'(o_underflow), 32'd1);
    chk("uflow_empty", 32'(o_empty), 32'd1);
    drain("uflow");

    // Negative zero counts as negative.
    push(32'h8000_0000);
    pop(32'h3F80_0000, 32'h3E80_0000);
    drain("negzero");

    // Fill to DEPTH, overflow once, then read all back.
    for (int i = 0; i < 64; i++) begin
      s = (i % 3 == 0);
      push(s ? 32'hC000_0000 : 32'h4000_0000);
    end
    idle();
    chk("fill_full",  32'(o_full),     32'd1);
    chk("fill_oflow", 32'(o_overflow), 32'd0);
    push(32'h4000_0000);
    idle();
    chk("oflow_flag", 32'(o_overflow), 32'd1);
    chk("oflow_full", 32'(o_full),     32'd1);
    for (int i = 0; i < 64; i++) begin
      s = (i % 3 == 0);
      pop(32'h3F80_0000, s ? 32'h3E80_0000 : 32'h3F00_0000);
    end
    idle();
    chk("read_empty", 32'(o_empty), 32'd1);
    chk("read_full",  32'(o_full),  32'd0);
    drain("fill");

    // Concurrent push and pop at count 3.
    push(32'hC000_0000);
    push(32'h4000_0000);
    push(32'hC000_0000);
    drive(1'b1, 32'h4000_0000, 1'b1, 32'h3F80_0000, 1'b0, 1'b1, 32'h3E80_0000);
    idle();
    chk("conc_empty", 32'(o_empty), 32'd0);
    chk("conc_full",  32'(o_full),  32'd0);
    pop(32'h3F80_0000, 32'h3F00_0000);
    pop(32'h3F80_0000, 32'h3E80_0000);
    pop(32'h3F80_0000, 32'h3F00_0000);
    idle();
    chk("conc_drained", 32'(o_empty), 32'd1);
    drain("conc");

    // Flush beats a same-cycle push.
    push(32'hC000_0000);
    push(32'hC000_0000);
    drive(1'b1, 32'hC000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    idle();
    chk("flush_empty", 32'(o_empty), 32'd1);
    pop(32'h3F80_0000, 32'h3F00_0000);
    drain("flush");

    // Reset three cycles after an err discards the in-flight product.
    push(32'h4000_0000);
    drive(1'b0, 32'h0, 1'b1, 32'h3F80_0000, 1'b0, 1'b0, 32'h0);
    idle();
    idle();
    rst_n = 1'b1;
    idle();
    rst_n = 1'b0;
    repeat (10) idle();
    chk("midrst_quiet", 32'(mon_q.size()), 32'd0);
    chk("midrst_oflow", 32'(o_overflow),   32'd0);
    chk("midrst_uflow", 32'(o_underflow),  32'd0);
    chk("midrst_full",  32'(o_full),       32'd0);
    chk("midrst_empty", 32'(o_empty),      32'd1);
    mon_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
